axi_lite_times_rom: RTL and testbench

//  AXI4-Lite read-only slave that serves the 0..7 x 0..7 times table; the memory stage sitting

---
 rtl/axi_lite_times_rom.sv | 170 +++++++++++++++++
 tb/tb_axi_lite_times_rom.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/axi_lite_times_rom.sv
// AXI4-Lite read-only slave serving the OPW x OPW times table with a fixed,
// configurable read latency; writes are accepted but answered with SLVERR.
module axi_lite_times_rom #(
    parameter int OPW          = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [15:0] rd_count
);

    localparam int IW = 2 * OPW;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Table entry {a,b} -> a*b, zero-extended to the bus width
    function automatic logic [31:0] times_entry(input logic [IW-1:0] idx);
        logic [IW-1:0] prod;
        prod = IW'(idx[IW-1:OPW]) * IW'(idx[OPW-1:0]);
        return {{(32-IW){1'b0}}, prod};
    endfunction

    logic [1:0]  rd_state_r;
    logic [3:0]  lat_cnt_r;
    logic [0:0]  wr_state_r;
    logic        aw_seen_r;
    logic        w_seen_r;

    logic        ar_hs_s;
    logic        in_range_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        aw_done_s;
    logic        w_done_s;
    logic        unused_s;

    assign ar_hs_s    = s_axi_arvalid & s_axi_arready;
    assign in_range_s = (s_axi_araddr[31:IW] == '0);
    assign aw_hs_s    = s_axi_awvalid & s_axi_awready;
    assign w_hs_s     = s_axi_wvalid & s_axi_wready;
    assign aw_done_s  = aw_seen_r | aw_hs_s;
    assign w_done_s   = w_seen_r | w_hs_s;
    assign unused_s   = ^{s_axi_awaddr, s_axi_wdata, s_axi_wstrb};

    // Read channel: address accept, latency countdown, data hold until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r    <= R_IDLE;
            lat_cnt_r     <= 4'd0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'd0;
            s_axi_rresp   <= 2'b00;
            rd_count      <= 16'd0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rdata   <= in_range_s ? times_entry(s_axi_araddr[IW-1:0]) : 32'd0;
                        s_axi_rresp   <= in_range_s ? RESP_OKAY : RESP_DECERR;
                        lat_cnt_r     <= 4'(READ_LATENCY);
                        rd_state_r    <= (READ_LATENCY == 0) ? R_DATA : R_WAIT;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt_r == 4'd0) begin
                        s_axi_rvalid <= 1'b1;
                        rd_state_r   <= R_DATA;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                R_DATA: begin
                    // Zero-latency reads arrive here with rvalid still low
                    if (!s_axi_rvalid) begin
                        s_axi_rvalid <= 1'b1;
                    end else if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_count      <= rd_count + 16'd1;
                        rd_state_r    <= R_IDLE;
                    end else begin
                        s_axi_rvalid <= 1'b1;
                    end
                end
                default: begin
                    s_axi_rvalid  <= 1'b0;
                    s_axi_arready <= 1'b0;
                    rd_state_r    <= R_IDLE;
                end
            endcase
        end
    end

    // Write channel: collect AW and W in any order, then answer SLVERR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_r    <= W_IDLE;
            aw_seen_r     <= 1'b0;
            w_seen_r      <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_done_s && w_done_s) begin
                        aw_seen_r     <= 1'b0;
                        w_seen_r      <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= RESP_SLVERR;
                        wr_state_r    <= W_RESP;
                    end else begin
                        aw_seen_r     <= aw_done_s;
                        w_seen_r      <= w_done_s;
                        s_axi_awready <= ~aw_done_s;
                        s_axi_wready  <= ~w_done_s;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wr_state_r    <= W_IDLE;
                    end else begin
                        s_axi_bvalid <= 1'b1;
                    end
                end
                default: begin
                    s_axi_bvalid <= 1'b0;
                    wr_state_r   <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_times_rom.sv
// Directed self-checking bench for axi_lite_times_rom (OPW=3, READ_LATENCY=1).
module tb_axi_lite_times_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] rd_count;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_times_rom #(.OPW(3), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one read, checks latency, data, stall hold and completion
    task automatic do_read(input logic [31:0] addr, input int stall,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input logic [15:0] exp_count);
        int lat;
        check_eq("arready_before_ar", {31'd0, arready}, 32'd1);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("arready_after_ar", {31'd0, arready}, 32'd0);
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rvalid_latency", lat, 32'd2);
        check_eq("rdata", rdata, exp_data);
        check_eq("rresp", {30'd0, rresp}, {30'd0, exp_resp});
        for (int i = 0; i < stall; i++) begin
            check_eq("rvalid_stall", {31'd0, rvalid}, 32'd1);
            check_eq("rdata_stall", rdata, exp_data);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        check_eq("rvalid_done", {31'd0, rvalid}, 32'd0);
        check_eq("rd_count", {16'd0, rd_count}, {16'd0, exp_count});
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst = 1'b1; araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b0;

        // Reset state and ready rise one edge after release
        repeat (2) @(negedge clk);
        check_eq("rst_arready", {31'd0, arready}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_rd_count", {16'd0, rd_count}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_arready_pre", {31'd0, arready}, 32'd0);
        @(negedge clk);
        check_eq("rel_arready", {31'd0, arready}, 32'd1);
        check_eq("rel_awready", {31'd0, awready}, 32'd1);
        check_eq("rel_wready", {31'd0, wready}, 32'd1);

        // 3*5, 7*7 with stall, out of range, index 0
        do_read(32'h0000_001D, 0, 32'd15, 2'b00, 16'd1);
        do_read(32'h0000_003F, 3, 32'd49, 2'b00, 16'd2);
        do_read(32'h0000_0040, 0, 32'd0,  2'b11, 16'd3);
        do_read(32'h0000_0000, 0, 32'd0,  2'b00, 16'd4);

        // W two cycles ahead of AW
        bready = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("wready_after_w", {31'd0, wready}, 32'd0);
        check_eq("bvalid_w_only", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        awaddr  = 32'h0000_0012;
        awvalid = 1'b1;
        seen = 0;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("bvalid", {31'd0, bvalid}, 32'd1);
        check_eq("bresp", {30'd0, bresp}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (bvalid) seen++;
            @(negedge clk);
        end
        check_eq("bvalid_count", seen, 32'd1);
        check_eq("awready_back", {31'd0, awready}, 32'd1);
        check_eq("wready_back", {31'd0, wready}, 32'd1);
        do_read(32'h0000_0012, 0, 32'd4, 2'b00, 16'd5);

        // Reset in the middle of a read's wait phase
        araddr  = 32'h0000_003F;
        arvalid = 1'b1;
        rready  = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("async_arready", {31'd0, arready}, 32'd0);
        check_eq("async_awready", {31'd0, awready}, 32'd0);
        check_eq("async_rdata", rdata, 32'd0);
        check_eq("async_rd_count", {16'd0, rd_count}, 32'd0);
        @(negedge clk);
        arvalid = 1'b0;
        rst     = 1'b0;
        #1;
        check_eq("rel2_arready_pre", {31'd0, arready}, 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rvalid) seen++;
        end
        check_eq("no_rvalid_after_rst", seen, 32'd0);
        do_read(32'h0000_0009, 0, 32'd1, 2'b00, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
